// File: rtl/serial_adder_pkg.sv
// Shared types for the serial adder: FSM state encoding and a counter-width helper.
// Used by serial_adder; see serial_adder.sv for the SERIAL_ADDER_SUB_EN option.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Step counter must hold 0..n-1; keep at least one bit for n == 1.
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder; serial_adder chains STEP of these per clock.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds STEP bits per clock through a ripple chain of fa_cell, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (computes a + ~b + 1, c_in ignored).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = cnt_bits(N);

  generate
    if (STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_step
      $error("serial_adder: WIDTH must be a positive multiple of STEP");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [STEP:0]    chain;
  logic [STEP-1:0]  step_sum;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             accept;
  logic             last_step;

  assign chain[0] = carry;

  generate
    for (genvar i = 0; i < STEP; i++) begin : g_fa
      fa_cell u_fa (
        .a    (opa[i]),
        .b    (opb[i]),
        .cin  (chain[i]),
        .s    (step_sum[i]),
        .cout (chain[i+1])
      );
    end
  endgenerate

  // Partial result fills from the MSB side; the oldest bits reach the LSB after N steps.
  generate
    if (WIDTH > STEP) begin : g_part
      logic [WIDTH-STEP-1:0] part;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          part <= '0;
        end else if (state == RUN) begin
          part <= acc_next[WIDTH-1:STEP];
        end
      end

      assign acc_next = {step_sum, part};
    end else begin : g_no_part
      assign acc_next = step_sum;
    end
  endgenerate

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.c_in;
`else
  assign b_load = bus.b;
  assign c_load = bus.c_in;
`endif

  assign accept    = bus.start && (state != RUN);
  assign last_step = (cnt == CW'(N - 1));

  // Result outputs are only written on the RUN->DONE transition, so they hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.sum   <= '0;
      bus.c_out <= 1'b0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            opa      <= bus.a;
            opb      <= b_load;
            carry    <= c_load;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> STEP;
          opb   <= opb >> STEP;
          carry <= chain[STEP];
          if (last_step) begin
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            bus.sum   <= acc_next;
            bus.c_out <= chain[STEP];
            bus.ovf   <= chain[STEP] ^ chain[STEP-1];
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
